system_acl_iface_pll_lock_ctrl: RTL

Sequences the reset and lock bring-up of the interface PLL from the reference-clock domain. It issues a timed PLL reset pulse and waits for a stable lock, with a timeout and bounded retries. It then releases a kernel-side reset and keeps monitoring for loss of lock. It sits between the board reset and the temperature/kernel PLL instance, and exposes status to the ACL interface CSR logic.

---
 rtl/system_acl_iface_pll_pkg.sv | 26 ++
 rtl/acl_pll_lock_sync.sv | 32 +++
 rtl/system_acl_iface_pll_lock_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/system_acl_iface_pll_pkg.sv
// ---------------------------------------------------------------------------
// system_acl_iface_pll_pkg
// Shared definitions for the interface PLL lock controller:
//   - pll_state_e : controller state, encoding is visible through the CSR
//                   readback port, so the values are fixed.
//   - STATE_W     : width of the state encoding.
//   - cnt_width() : width of a counter that must hold 0..max_val inclusive.
// ---------------------------------------------------------------------------
package system_acl_iface_pll_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StAssertRst = 3'd0,
        StWaitLock  = 3'd1,
        StStable    = 3'd2,
        StRun       = 3'd3,
        StFail      = 3'd4
    } pll_state_e;

    // One bit of headroom above $clog2 so the terminal value itself fits.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/acl_pll_lock_sync.sv
// ---------------------------------------------------------------------------
// acl_pll_lock_sync
// Generic two-flop synchronizer for a single asynchronous level signal.
// Output lags the input by two clk edges and resets to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input level
//   q     : synchronized output
// ---------------------------------------------------------------------------
module acl_pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/system_acl_iface_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// system_acl_iface_pll_lock_ctrl
// Brings up the interface PLL from the reference-clock domain: pulses the
// PLL reset, waits for a qualified (stable) lock with a timeout and bounded
// retries, then releases the kernel-side reset and watches for loss of lock.
//
// Ports:
//   clk           : reference clock (same net as the PLL refclk)
//   resetn        : asynchronous active-low reset
//   pll_locked    : PLL lock indication, asynchronous to clk
//   relock_req    : one-cycle pulse, restarts bring-up from any state
//   pll_rst       : active-high PLL reset
//   kernel_resetn : active-low reset for PLL-clocked logic (registered)
//   pll_ready     : high only while in RUN
//   pll_fail      : high only while in FAIL
//   loss_count    : saturating count of lock losses seen in RUN
//   state_o       : current state encoding for CSR readback
// ---------------------------------------------------------------------------
module system_acl_iface_pll_lock_ctrl
    import system_acl_iface_pll_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned LOSS_CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  kernel_resetn,
    output logic                  pll_ready,
    output logic                  pll_fail,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [STATE_W-1:0]    state_o
);

    localparam int unsigned PULSE_W = cnt_width(RST_PULSE_CYCLES);
    localparam int unsigned STAB_W  = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TMO_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned RETRY_W = cnt_width(MAX_RETRIES);

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    pll_state_e            state_q, state_d;
    logic [PULSE_W-1:0]    pulse_q, pulse_d;
    logic [STAB_W-1:0]     stab_q, stab_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [RETRY_W-1:0]    retry_inc;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    logic pll_rst_q;
    logic kernel_resetn_q;
    logic pll_ready_q;
    logic pll_fail_q;

    logic lock_s;
    logic timeout;

    acl_pll_lock_sync u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign retry_inc = retry_q + 1'b1;

    // Timeout is judged on the current count; it only applies while hunting
    // for lock and loses to a RUN entry on the same cycle.
    assign timeout = ((state_q == StWaitLock) || (state_q == StStable)) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            StAssertRst: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = StWaitLock;
                    pulse_d = '0;
                    tmo_d   = '0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end

            StWaitLock: begin
                tmo_d = tmo_q + 1'b1;
                if (lock_s) begin
                    state_d = StStable;
                    stab_d  = '0;
                end
            end

            StStable: begin
                // Timeout keeps running across glitches so a flapping lock
                // cannot hold the controller here forever.
                tmo_d = tmo_q + 1'b1;
                if (!lock_s) begin
                    state_d = StWaitLock;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = StRun;
                    retry_d = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end

            StRun: begin
                if (!lock_s) begin
                    state_d = StAssertRst;
                    if (loss_q != {LOSS_CNT_W{1'b1}}) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end

            StFail: begin
                state_d = StFail;
            end

            default: begin
                state_d = StAssertRst;
                pulse_d = '0;
            end
        endcase

        if (timeout && (state_d != StRun)) begin
            retry_d = retry_inc;
            stab_d  = '0;
            state_d = (retry_inc == RETRY_MAX) ? StFail : StAssertRst;
        end

        // Relock overrides everything, including a same-cycle loss of lock,
        // which therefore must not be counted.
        if (relock_req) begin
            state_d = StAssertRst;
            pulse_d = '0;
            retry_d = '0;
            stab_d  = '0;
            loss_d  = loss_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= StAssertRst;
            pulse_q         <= '0;
            stab_q          <= '0;
            tmo_q           <= '0;
            retry_q         <= '0;
            loss_q          <= '0;
            pll_rst_q       <= 1'b1;
            kernel_resetn_q <= 1'b0;
            pll_ready_q     <= 1'b0;
            pll_fail_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            pulse_q         <= pulse_d;
            stab_q          <= stab_d;
            tmo_q           <= tmo_d;
            retry_q         <= retry_d;
            loss_q          <= loss_d;
            // Outputs decode the next state so they change on the same edge
            // as the state register, glitch-free.
            pll_rst_q       <= (state_d == StAssertRst);
            kernel_resetn_q <= (state_d == StRun);
            pll_ready_q     <= (state_d == StRun);
            pll_fail_q      <= (state_d == StFail);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign kernel_resetn = kernel_resetn_q;
    assign pll_ready     = pll_ready_q;
    assign pll_fail      = pll_fail_q;
    assign loss_count    = loss_q;
    assign state_o       = state_q;

endmodule
